// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master port among NREQ requesters.
// Optional ACCESS wait-state timeout enabled by defining APB_TIMEOUT_EN.
module apb_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               Hclk,
    input  logic               Hresetn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*32-1:0] req_addr,
    input  logic [NREQ*32-1:0] req_wdata,
    input  logic [NREQ*3-1:0]  req_selx,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    req_done,
    output logic [31:0]        req_rdata,
    output logic               req_err,
    output logic [31:0]        Paddr,
    output logic [31:0]        Pwdata,
    output logic               Pwrite,
    output logic               Penable,
    output logic [2:0]         Pselx,
    input  logic [31:0]        Prdata,
    input  logic               Pready
);

    localparam int IDX_W = $clog2(NREQ);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("apb_rr_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
    end

    logic [1:0]       state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] owner;

    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  win_onehot;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;
    logic [31:0]      win_addr;
    logic [31:0]      win_wdata;
    logic             win_write;
    logic [2:0]       win_selx;
    logic             timed_out;

`ifdef APB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_cnt;
    // The cycle whose increment would reach TIMEOUT is the terminating one.
    assign timed_out = (wait_cnt == WAIT_W'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        // A requester in its done cycle still shows req_valid; mask it out.
        eligible   = req_valid & ~req_done;
        win_found  = 1'b0;
        win_idx    = '0;
        cand       = '0;
        win_onehot = '0;
        win_addr   = '0;
        win_wdata  = '0;
        win_write  = 1'b0;
        win_selx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(last) + k) % NREQ);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_onehot[i] = win_found;
                win_addr      = req_addr[i*32 +: 32];
                win_wdata     = req_wdata[i*32 +: 32];
                win_write     = req_write[i];
                win_selx      = req_selx[i*3 +: 3];
            end
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state     <= ST_IDLE;
            last      <= IDX_W'(NREQ - 1);
            owner     <= '0;
            grant     <= '0;
            req_done  <= '0;
            req_rdata <= '0;
            req_err   <= 1'b0;
            Paddr     <= '0;
            Pwdata    <= '0;
            Pwrite    <= 1'b0;
            Penable   <= 1'b0;
            Pselx     <= '0;
`ifdef APB_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            req_done <= '0;
            req_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    Penable <= 1'b0;
                    if (win_found) begin
                        grant  <= win_onehot;
                        owner  <= win_idx;
                        Paddr  <= win_addr;
                        Pwrite <= win_write;
                        Pselx  <= win_selx;
                        if (win_write) Pwdata <= win_wdata;
                        state  <= ST_SETUP;
                    end else begin
                        grant <= '0;
                        Pselx <= '0;
                    end
                end
                ST_SETUP: begin
                    Penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (Pready || timed_out) begin
                        req_done  <= grant;
                        req_rdata <= (Pready && !Pwrite) ? Prdata : 32'h0;
                        req_err   <= ~Pready;
                        Pselx     <= '0;
                        Penable   <= 1'b0;
                        grant     <= '0;
                        last      <= owner;
                        state     <= ST_IDLE;
                    end else begin
`ifdef APB_TIMEOUT_EN
                        wait_cnt <= wait_cnt + WAIT_W'(1);
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Self-checking bench for apb_rr_arbiter: transfer-level model plus directed scenarios.
module tb_apb_rr_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic               Hclk = 1'b0;
    logic               Hresetn;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*32-1:0] req_addr;
    logic [NREQ*32-1:0] req_wdata;
    logic [NREQ*3-1:0]  req_selx;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    req_done;
    logic [31:0]        req_rdata;
    logic               req_err;
    logic [31:0]        Paddr;
    logic [31:0]        Pwdata;
    logic               Pwrite;
    logic               Penable;
    logic [2:0]         Pselx;
    logic [31:0]        Prdata;
    logic               Pready;

    int errors = 0;
    int checks = 0;

    apb_rr_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_selx(req_selx),
        .grant(grant), .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err),
        .Paddr(Paddr), .Pwdata(Pwdata), .Pwrite(Pwrite), .Penable(Penable), .Pselx(Pselx),
        .Prdata(Prdata), .Pready(Pready)
    );

    always #5 Hclk = ~Hclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] s);
        req_write[i]         = w;
        req_addr[32*i +: 32] = a;
        req_wdata[32*i +: 32] = d;
        req_selx[3*i +: 3]   = s;
    endtask

`ifdef APB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // Transfer-level model: a transfer is granted, then ages through setup and access.
    function automatic int pick(input logic [NREQ-1:0] elig, input int from);
        for (int k = 1; k <= NREQ; k++)
            if (elig[(from + k) % NREQ]) return (from + k) % NREQ;
        return -1;
    endfunction

    logic            m_busy;
    int              m_age, m_owner, m_last, m_waits, m_pick;
    logic [NREQ-1:0] m_grant, m_done;
    logic [31:0]     m_rdata, m_addr, m_wdata;
    logic            m_err, m_write, m_en;
    logic [2:0]      m_sel;

    always_comb m_pick = pick(req_valid & ~m_done, m_last);

    always @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            m_busy <= 1'b0; m_age <= 0; m_owner <= 0; m_last <= NREQ - 1; m_waits <= 0;
            m_grant <= '0; m_done <= '0; m_rdata <= '0; m_err <= 1'b0;
            m_addr <= '0; m_wdata <= '0; m_write <= 1'b0; m_en <= 1'b0; m_sel <= '0;
        end else begin
            m_done <= '0;
            m_err  <= 1'b0;
            if (!m_busy) begin
                m_en <= 1'b0;
                if (m_pick >= 0) begin
                    m_busy  <= 1'b1;
                    m_age   <= 1;
                    m_owner <= m_pick;
                    m_grant <= NREQ'(1) << m_pick;
                    m_addr  <= req_addr[32*m_pick +: 32];
                    m_write <= req_write[m_pick];
                    m_sel   <= req_selx[3*m_pick +: 3];
                    if (req_write[m_pick]) m_wdata <= req_wdata[32*m_pick +: 32];
                end else begin
                    m_grant <= '0;
                    m_sel   <= '0;
                end
            end else if (m_age == 1) begin
                m_age   <= 2;
                m_en    <= 1'b1;
                m_waits <= 0;
            end else if (Pready || (TO_EN && m_waits + 1 >= TIMEOUT)) begin
                m_busy  <= 1'b0;
                m_done  <= NREQ'(1) << m_owner;
                m_rdata <= (Pready && !m_write) ? Prdata : 32'h0;
                m_err   <= !Pready;
                m_grant <= '0;
                m_sel   <= '0;
                m_en    <= 1'b0;
                m_last  <= m_owner;
            end else begin
                m_waits <= m_waits + 1;
            end
        end
    end

    always @(negedge Hclk) begin
        if (Hresetn === 1'b1) begin
            check("model_grant",   32'(grant),   32'(m_grant));
            check("model_done",    32'(req_done), 32'(m_done));
            check("model_rdata",   req_rdata,    m_rdata);
            check("model_err",     32'(req_err), 32'(m_err));
            check("model_paddr",   Paddr,        m_addr);
            check("model_pwdata",  Pwdata,       m_wdata);
            check("model_pwrite",  32'(Pwrite),  32'(m_write));
            check("model_penable", 32'(Penable), 32'(m_en));
            check("model_pselx",   32'(Pselx),   32'(m_sel));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NREQ-1:0] exp_ord [5];
        logic [NREQ-1:0] order [$];
        int              times [$];
        logic [NREQ-1:0] prev_g;
        int              done_at;
        logic            err_seen;
        logic [31:0]     rd_seen;

        Hresetn = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_selx = '0;
        Prdata = '0; Pready = 1'b0;
        #2;
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_apb", {Penable, Pwrite, Pselx, 27'h0} | Paddr | Pwdata, 32'h0);
        check("reset_done", 32'(req_done) | req_rdata | 32'(req_err), 32'h0);
        #10 Hresetn = 1'b1;

        // Single zero-wait read from requester 0.
        tick();
        set_req(0, 1'b0, 32'h0000_1000, 32'h0, 3'b001);
        req_valid = 4'b0001; Prdata = 32'hA5A5_5A5A; Pready = 1'b1;
        tick();
        check("rd_setup_pselx", 32'(Pselx), 32'h1);
        check("rd_setup_penable", 32'(Penable), 32'h0);
        check("rd_setup_paddr", Paddr, 32'h0000_1000);
        check("rd_setup_grant", 32'(grant), 32'h1);
        tick();
        check("rd_access_penable", 32'(Penable), 32'h1);
        tick();
        check("rd_done", 32'(req_done), 32'h1);
        check("rd_rdata", req_rdata, 32'hA5A5_5A5A);
        req_valid = '0;
        tick();
        check("rd_done_pulse", 32'(req_done), 32'h0);
        check("rd_rdata_hold", req_rdata, 32'hA5A5_5A5A);

        // Write from requester 2 with three wait states.
        set_req(2, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 3'b100);
        req_valid = 4'b0100; Pready = 1'b0;
        tick();
        check("wr_setup_grant", 32'(grant), 32'h4);
        check("wr_setup_pwdata", Pwdata, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wr_access_penable", 32'(Penable), 32'h1);
            check("wr_access_pwrite", 32'(Pwrite), 32'h1);
            check("wr_access_pwdata", Pwdata, 32'hDEAD_BEEF);
            check("wr_access_nodone", 32'(req_done), 32'h0);
            if (i == 3) Pready = 1'b1;
        end
        tick();
        check("wr_done", 32'(req_done), 32'h4);
        check("wr_rdata_zero", req_rdata, 32'h0);
        req_valid = '0;
        tick();

        // All requesters continuously active after a fresh reset.
        Hresetn = 1'b0;
        #3 Hresetn = 1'b1;
        req_write = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 32'h100 * i, 32'h0, 3'(i + 1));
        Prdata = 32'h0BAD_F00D;
        req_valid = 4'b1111;
        prev_g = '0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (grant != '0 && prev_g == '0) begin
                order.push_back(grant);
                times.push_back(c);
            end
            prev_g = grant;
        end
        req_valid = '0;
        tick();
        exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        check("rr_count", 32'(order.size()), 32'd5);
        for (int j = 0; j < 5 && j < order.size(); j++) begin
            check("rr_order", 32'(order[j]), 32'(exp_ord[j]));
            if (j > 0) check("rr_spacing", 32'(times[j] - times[j-1]), 32'd3);
        end

        // Reset during the ACCESS phase of requester 1.
        set_req(1, 1'b0, 32'h0000_3000, 32'h0, 3'b010);
        req_valid = 4'b0010; Pready = 1'b0;
        tick();
        tick();
        check("rst_pre_penable", 32'(Penable), 32'h1);
        #1 Hresetn = 1'b0;
        #1;
        check("rst_async_grant", 32'(grant), 32'h0);
        check("rst_async_apb", {Penable, Pwrite, Pselx, 27'h0} | Paddr | Pwdata, 32'h0);
        check("rst_async_done", 32'(req_done) | req_rdata | 32'(req_err), 32'h0);
        Pready = 1'b1;
        tick();
        check("rst_hold_done", 32'(req_done), 32'h0);
        req_valid = 4'b0011;
        @(negedge Hclk);
        Hresetn = 1'b1;
        tick();
        check("rst_first_grant", 32'(grant), 32'h1);
        tick();
        tick();
        check("rst_req0_done", 32'(req_done), 32'h1);
        req_valid = 4'b0010;
        tick();
        check("rst_then_grant1", 32'(grant), 32'h2);
        tick();
        tick();
        check("rst_req1_done", 32'(req_done), 32'h2);
        req_valid = '0;
        tick();

        // Slave never ready.
        set_req(3, 1'b0, 32'h0000_4000, 32'h0, 3'b011);
        Prdata = 32'h1234_5678; Pready = 1'b0;
        req_valid = 4'b1000;
        done_at = -1; err_seen = 1'b0; rd_seen = '1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (req_done != '0 && done_at < 0) begin
                done_at  = c;
                err_seen = req_err;
                rd_seen  = req_rdata;
            end
        end
`ifdef APB_TIMEOUT_EN
        check("to_done_cycle", 32'(done_at), 32'd18);
        check("to_err", 32'(err_seen), 32'h1);
        check("to_rdata", rd_seen, 32'h0);
`else
        check("stall_no_done", 32'(done_at), 32'hFFFF_FFFF);
        check("stall_penable", 32'(Penable), 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
